// File: rtl/ldq_ddr_arbiter_if.sv
// Bundle of the load-queue request/return ports and the memory-controller read port
// shared by ldq_ddr_arbiter (slave side) and whatever drives it (master side).
interface ldq_ddr_arbiter_if #(
  parameter int NUM_LDQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DDR_DATA_WIDTH = 512
);
  logic [NUM_LDQ-1:0]                ldq_ddr_addr_valid;
  logic [NUM_LDQ-1:0]                ldq_ddr_addr_ready;
  logic [NUM_LDQ*ADDR_WIDTH-1:0]     ldq_ddr_addr;
  logic [NUM_LDQ-1:0]                ldq_ddr_data_valid;
  logic [NUM_LDQ*DDR_DATA_WIDTH-1:0] ldq_ddr_data;
  logic                              mem_addr_valid;
  logic                              mem_addr_ready;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic                              mem_data_valid;
  logic [DDR_DATA_WIDTH-1:0]         mem_data;
  logic                              tag_err;

  modport master (
    output ldq_ddr_addr_valid, ldq_ddr_addr, mem_addr_ready, mem_data_valid, mem_data,
    input  ldq_ddr_addr_ready, ldq_ddr_data_valid, ldq_ddr_data, mem_addr_valid, mem_addr, tag_err
  );

  modport slave (
    input  ldq_ddr_addr_valid, ldq_ddr_addr, mem_addr_ready, mem_data_valid, mem_data,
    output ldq_ddr_addr_ready, ldq_ddr_data_valid, ldq_ddr_data, mem_addr_valid, mem_addr, tag_err
  );
endinterface

// File: rtl/ldq_ddr_arbiter.sv
// Round-robin arbiter sharing one DDR read channel among NUM_LDQ load queues, with an in-order
// tag FIFO steering returned beats. Optional counters: define LDQ_DDR_ARB_PERF_CNT_EN.
module ldq_ddr_arbiter #(
  parameter int NUM_LDQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DDR_DATA_WIDTH = 512,
  parameter int TAG_PTR_WIDTH  = 4
) (
  input  logic                  ddr_clk,
  input  logic                  ddr_rstn,
`ifdef LDQ_DDR_ARB_PERF_CNT_EN
  output logic [31:0]           perf_stall_cnt,
  output logic [NUM_LDQ*32-1:0] perf_grant_cnt,
`endif
  ldq_ddr_arbiter_if.slave      bus
);
  localparam int LDQ_W = $clog2(NUM_LDQ);
  localparam int DEPTH = 1 << TAG_PTR_WIDTH;

  typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} addr_state_e;

  addr_state_e               state_r, state_s;
  logic [LDQ_W-1:0]          rr_ptr_r;
  logic [ADDR_WIDTH-1:0]     mem_addr_r;
  logic [LDQ_W-1:0]          tag_mem_r [DEPTH];
  logic [TAG_PTR_WIDTH:0]    wr_ptr_r, rd_ptr_r;
  logic [NUM_LDQ-1:0]        data_valid_r;
  logic [DDR_DATA_WIDTH-1:0] data_r;
  logic                      tag_err_r;

  logic                      fifo_full_s, fifo_empty_s, can_load_s, win_found_s, grant_s, pop_s;
  logic [LDQ_W-1:0]          win_idx_s, head_tag_s;
  logic [ADDR_WIDTH-1:0]     win_addr_s;

  function automatic logic [NUM_LDQ-1:0] one_hot(input logic [LDQ_W-1:0] idx);
    one_hot = {{(NUM_LDQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[TAG_PTR_WIDTH-1:0] == rd_ptr_r[TAG_PTR_WIDTH-1:0]) &&
                        (wr_ptr_r[TAG_PTR_WIDTH] != rd_ptr_r[TAG_PTR_WIDTH]);
  assign head_tag_s   = tag_mem_r[rd_ptr_r[TAG_PTR_WIDTH-1:0]];
  assign can_load_s   = ((state_r == ST_EMPTY) || bus.mem_addr_ready) && !fifo_full_s;
  // No grant is issued while reset is asserted, so ready reads 0 during reset.
  assign grant_s      = can_load_s && win_found_s && ddr_rstn;
  assign pop_s        = bus.mem_data_valid && !fifo_empty_s;

  // Winner search: first pass covers rr_ptr..NUM_LDQ-1, second pass wraps to 0..rr_ptr-1.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int j = 0; j < NUM_LDQ; j++) begin
      if (!win_found_s && bus.ldq_ddr_addr_valid[j] && (LDQ_W'(j) >= rr_ptr_r)) begin
        win_found_s = 1'b1;
        win_idx_s   = LDQ_W'(j);
      end else begin
        win_found_s = win_found_s;
      end
    end
    for (int j = 0; j < NUM_LDQ; j++) begin
      if (!win_found_s && bus.ldq_ddr_addr_valid[j]) begin
        win_found_s = 1'b1;
        win_idx_s   = LDQ_W'(j);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Address mux selecting the winner's slice.
  always_comb begin
    win_addr_s = '0;
    for (int j = 0; j < NUM_LDQ; j++) begin
      if (win_idx_s == LDQ_W'(j)) begin
        win_addr_s = bus.ldq_ddr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  // Per-queue accept strobe.
  always_comb begin
    bus.ldq_ddr_addr_ready = grant_s ? one_hot(win_idx_s) : '0;
  end

  // Address stage next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (grant_s) state_s = ST_HOLD;
        else         state_s = ST_EMPTY;
      end
      ST_HOLD: begin
        if (grant_s)                 state_s = ST_HOLD;
        else if (bus.mem_addr_ready) state_s = ST_EMPTY;
        else                         state_s = ST_HOLD;
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // Address register, round-robin pointer and tag FIFO write side.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_r    <= ST_EMPTY;
      rr_ptr_r   <= '0;
      mem_addr_r <= '0;
      wr_ptr_r   <= '0;
      for (int i = 0; i < DEPTH; i++) tag_mem_r[i] <= '0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        mem_addr_r                                <= win_addr_s;
        tag_mem_r[wr_ptr_r[TAG_PTR_WIDTH-1:0]]    <= win_idx_s;
        wr_ptr_r                                  <= wr_ptr_r + {{TAG_PTR_WIDTH{1'b0}}, 1'b1};
        if (win_idx_s == LDQ_W'(NUM_LDQ - 1)) rr_ptr_r <= '0;
        else                                  rr_ptr_r <= win_idx_s + {{(LDQ_W-1){1'b0}}, 1'b1};
      end else begin
        mem_addr_r <= mem_addr_r;
        wr_ptr_r   <= wr_ptr_r;
        rr_ptr_r   <= rr_ptr_r;
      end
    end
  end

  // Return path: tag FIFO read side, data steering and sticky underflow flag.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      rd_ptr_r     <= '0;
      data_valid_r <= '0;
      data_r       <= '0;
      tag_err_r    <= 1'b0;
    end else begin
      if (pop_s) begin
        rd_ptr_r     <= rd_ptr_r + {{TAG_PTR_WIDTH{1'b0}}, 1'b1};
        data_valid_r <= one_hot(head_tag_s);
        data_r       <= bus.mem_data;
      end else begin
        rd_ptr_r     <= rd_ptr_r;
        data_valid_r <= '0;
        data_r       <= data_r;
      end
      if (bus.mem_data_valid && fifo_empty_s) tag_err_r <= 1'b1;
      else                                    tag_err_r <= tag_err_r;
    end
  end

  assign bus.mem_addr_valid     = (state_r == ST_HOLD);
  assign bus.mem_addr           = mem_addr_r;
  assign bus.ldq_ddr_data_valid = data_valid_r;
  assign bus.ldq_ddr_data       = {NUM_LDQ{data_r}};
  assign bus.tag_err            = tag_err_r;

`ifdef LDQ_DDR_ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] grant_cnt_r [NUM_LDQ];

  // Saturating stall and per-queue grant counters.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      stall_cnt_r <= 32'd0;
      for (int i = 0; i < NUM_LDQ; i++) grant_cnt_r[i] <= 32'd0;
    end else begin
      if ((|bus.ldq_ddr_addr_valid) && fifo_full_s && (stall_cnt_r != 32'hFFFF_FFFF))
        stall_cnt_r <= stall_cnt_r + 32'd1;
      else
        stall_cnt_r <= stall_cnt_r;
      for (int i = 0; i < NUM_LDQ; i++) begin
        if (grant_s && (win_idx_s == LDQ_W'(i)) && (grant_cnt_r[i] != 32'hFFFF_FFFF))
          grant_cnt_r[i] <= grant_cnt_r[i] + 32'd1;
        else
          grant_cnt_r[i] <= grant_cnt_r[i];
      end
    end
  end

  // Flatten per-queue counters onto the output bus.
  always_comb begin
    perf_grant_cnt = '0;
    for (int i = 0; i < NUM_LDQ; i++) perf_grant_cnt[i*32 +: 32] = grant_cnt_r[i];
  end

  assign perf_stall_cnt = stall_cnt_r;
`else
  // Counters are not built in this configuration.
`endif
endmodule

// File: doc/ldq_ddr_arbiter.md
Name: ldq_ddr_arbiter

Overview:
- Shares one DDR read channel among NUM_LDQ load queues.
- Arbitrates their address requests round-robin and forwards the winner through a registered address stage.
- Records each grant's queue index in an in-order tag FIFO.
- Steers returning read data to the owning queue.
- Sits between the load-queue DDR-side ports and the single memory-controller read port, in the ddr_clk domain.

Parameters:
- NUM_LDQ, 4, number of requesting load queues (2..8).
- ADDR_WIDTH, 32, DDR byte address width.
- DDR_DATA_WIDTH, 512, read data beat width.
- TAG_PTR_WIDTH, 4, log2 of tag FIFO depth; depth = 16 outstanding reads.

Ports:
- ddr_clk  input  1  DDR-domain clock; all logic on rising edge.
- ddr_rstn  input  1  asynchronous active-low reset.
- ldq_ddr_addr_valid  input  NUM_LDQ  per-queue read request valid.
- ldq_ddr_addr_ready  output  NUM_LDQ  per-queue accept, one-hot or zero.
- ldq_ddr_addr  input  NUM_LDQ*ADDR_WIDTH  per-queue read address; slice i = queue i.
- ldq_ddr_data_valid  output  NUM_LDQ  one-hot return strobe to owning queue.
- ldq_ddr_data  output  NUM_LDQ*DDR_DATA_WIDTH  return data, replicated into every slice.
- mem_addr_valid  output  1  read request to memory controller.
- mem_addr_ready  input  1  controller accepts request.
- mem_addr  output  ADDR_WIDTH  read address to controller.
- mem_data_valid  input  1  read data beat; in request order; no backpressure.
- mem_data  input  DDR_DATA_WIDTH  read data beat.
- tag_err  output  1  sticky: data beat arrived with tag FIFO empty.

Behaviour:
- Reset values: all outputs 0; RR pointer = 0; tag FIFO empty; wr_ptr = rd_ptr = 0.
- Reset mid-operation discards all outstanding tags and any held request; no beats are emitted afterwards for those tags.

Address stage (a single output register):
- Register state is EMPTY or HOLD; mem_addr_valid = (state == HOLD).
- can_load = (EMPTY or mem_addr_ready) and tag FIFO not full.
- Winner = first i with ldq_ddr_addr_valid[i] = 1, scanning from rr_ptr upward modulo NUM_LDQ.
- When can_load and any request is valid, assert ldq_ddr_addr_ready[winner] combinationally in the same cycle. No other ready bit may be high.
- On that edge:
  - mem_addr <= ldq_ddr_addr slice[winner]; state <= HOLD.
  - Push winner index into the tag FIFO.
  - rr_ptr <= (winner+1) mod NUM_LDQ.
- Request-to-mem_addr_valid latency = 1 cycle.
- HOLD with mem_addr_ready = 1 and no new grant: state <= EMPTY.
- HOLD with mem_addr_ready = 0: mem_addr and mem_addr_valid hold stable; all ldq_ddr_addr_ready = 0.
- Back-to-back grants give full throughput (1 request/cycle) while mem_addr_ready stays high.
- rr_ptr changes only on a grant.

Tag FIFO:
- Depth 2^TAG_PTR_WIDTH. Pointers carry an extra wrap bit.
- full = (addresses equal and wrap bits differ); empty = (pointers equal).
- Full blocks grants; the tag is pushed at grant time, so in-flight entries in the address register count toward occupancy.
- Simultaneous push and pop when full: no push, because full blocks the grant that cycle; the pop proceeds. The grant resumes the next cycle.
- Simultaneous push and pop when non-full, non-empty: occupancy unchanged.

Return path:
- mem_data_valid = 1 with FIFO not empty:
  - Next cycle: ldq_ddr_data_valid = one-hot(head tag) and all slices of ldq_ddr_data = mem_data.
  - Pop the tag.
  - Latency = 1 cycle.
- mem_data_valid = 1 with FIFO empty: no strobe; tag_err <= 1 and stays set until reset.
- ldq_ddr_data_valid is low in every cycle without a registered beat. ldq_ddr_data holds its last value.

Optional Feature:
- Macro: LDQ_DDR_ARB_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_stall_cnt, 32 bits: counts cycles where any ldq_ddr_addr_valid = 1 and no grant occurs because the tag FIFO is full.
  - perf_grant_cnt, NUM_LDQ*32 bits: per-queue grant count.
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Round-robin fairness: all 4 valid continuously, addresses 0x100*i, mem_addr_ready = 1 → grants 0,1,2,3,0,1… one per cycle; mem_addr sequence 0x000, 0x100, 0x200, 0x300; each beat returned routes to one-hot 0001, 0010, 0100, 1000 in order.
- Memory backpressure: queue 2 requests 0x2000 while mem_addr_ready = 0 for 5 cycles → mem_addr = 0x2000 held stable with valid high; every ldq_ddr_addr_ready = 0 until the accept cycle; exactly one tag pushed.
- FIFO full: 16 grants with no data returned → 17th request stalls with ready = 0 (perf_stall_cnt increments when enabled). One mem_data_valid beat → that request is granted in the next cycle.
- Push and pop in the same cycle at occupancy 8: a grant and a return beat coincide → occupancy stays 8; the returned beat goes to the oldest tag's queue.
- Spurious data: mem_data_valid = 1 after reset with no requests → no ldq_ddr_data_valid; tag_err = 1 from the next cycle and stays set.
- Async reset mid-stream: assert ddr_rstn = 0 with 5 outstanding reads → all outputs 0 immediately. After release, a new request from queue 3 is granted first, rr_ptr having restarted at 0.
